lsu_req_queue: RTL
==================

LSU_REQ_QUEUE -- requirements
Module: lsu_req_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 2, request FIFO entries; power of two and at least 2.
REQ-002 SHALL have port: clk  input  1  single clock; all flops on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid / req_ready  input / output  1 / 1  pipeline request handshake.
REQ-005 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_addr / req_wdata  input  32 / 32  byte address and store data.
REQ-007 SHALL have port: req_sign_mask  input  4  bit[3] = sign-extend; bits[2:0] = 001 byte, 011 half, 111 word.
REQ-008 SHALL have ports to the data cache: addr (32), write_data (32), memread (1), memwrite (1) and sign_mask (4), all outputs; read_data (32) and clk_stall (1), inputs.
REQ-009 SHALL have port: rsp_valid  output  1  one-cycle response strobe.
REQ-010 SHALL have ports: rsp_rdata  output  32  load data; rsp_is_load  output  1; rsp_err  output  1  misaligned or illegal mask.
REQ-011 SHALL have port: busy  output  1  high when the FIFO is non-empty or the FSM is not in Q_IDLE.

Function
REQ-012 SHALL push an entry {write, addr, wdata, sign_mask} on each edge where req_valid && req_ready; req_ready = !full, with no dependence on same-cycle pop.
REQ-013 SHALL implement FSM states Q_IDLE, Q_ISSUE, Q_WAIT_HI, Q_WAIT_LO, Q_RESP.
REQ-014 SHALL transition Q_IDLE -> Q_ISSUE when the FIFO is non-empty and clk_stall==0; otherwise it SHALL hold.
REQ-015 Q_ISSUE SHALL last exactly one cycle: it pops the head, drives the cache ports from the head, asserts memread (load) or memwrite (store), then -> Q_WAIT_HI.
REQ-016 memread and memwrite SHALL be 0 in every state except Q_ISSUE; addr, write_data and sign_mask SHALL hold their last issued values outside Q_ISSUE.
REQ-017 Q_WAIT_HI SHALL move -> Q_WAIT_LO on clk_stall==1.
REQ-018 Q_WAIT_LO SHALL move -> Q_RESP on clk_stall==0 and SHALL register read_data into rsp_rdata on that edge for loads.
REQ-019 Q_RESP SHALL assert rsp_valid for one cycle, then -> Q_ISSUE if the FIFO is non-empty, else -> Q_IDLE.
REQ-020 SHALL detect misalignment at the head before issue: half with addr[0]=1, word with addr[1:0]!=0, or mask[2:0] not in {001,011,111}; such an entry SHALL pop without a cache command and go Q_ISSUE -> Q_RESP with rsp_err=1 and rsp_rdata=0.
REQ-021 Store responses SHALL carry rsp_is_load=0 and rsp_rdata=0.
REQ-022 Load latency SHALL be: accepted at cycle t with an empty FIFO and Q_IDLE -> Q_ISSUE at t+1 -> rsp_valid at t+5. Back-to-back issue period SHALL be 5 cycles.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from a (log2(DEPTH)+1)-bit count.
REQ-024 Responses SHALL be returned in request order; rsp has no backpressure.

Reset
REQ-025 On rst_n low the block SHALL asynchronously clear the FIFO and set the FSM to Q_IDLE. memread, memwrite, rsp_valid, rsp_err, rsp_is_load and busy SHALL be 0; addr, write_data, rsp_rdata = 0; sign_mask = 0.
REQ-026 After reset release mid-cache-transaction, the block SHALL NOT issue until clk_stall==0, per REQ-014.

Structure
REQ-027 A shared package lsu_pkg SHALL hold the FSM state enum, the sign-mask encodings (MASK_BYTE=001, MASK_HALF=011, MASK_WORD=111) and the LED MMIO address 32'h2000.
REQ-028 The FIFO SHALL be a separate sub-module, lsu_sync_fifo, parameterised by DEPTH and width; misalignment check and FSM SHALL remain in lsu_req_queue.

Verification
REQ-029 Word load: addr=0x10, mask=0111, cache model returns 0xDEADBEEF -> memread pulse at t+1; rsp_valid at t+5 with rsp_rdata=0xDEADBEEF, rsp_is_load=1, rsp_err=0.
REQ-030 Store byte: addr=0x2000, wdata=0xA5, mask=0001 -> one memwrite cycle with write_data=0xA5 and sign_mask=0001; rsp_valid with rsp_is_load=0.
REQ-031 Misaligned: half load at addr=0x3 -> no memread, rsp_err=1, rsp_rdata=0, rsp_valid at t+2.
REQ-032 Fill: 3 requests in consecutive cycles with the cache stalled -> req_ready=0 after 2 accepted; third accepted after first pop; responses in order.
REQ-033 Reset asserted during Q_WAIT_LO with clk_stall=1 -> all outputs 0 immediately; no issue until clk_stall drops, then a new request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, mask encodings and alignment helper for the LSU request queue
package lsu_pkg;
    typedef enum logic [2:0] {Q_IDLE, Q_ISSUE, Q_WAIT_HI, Q_WAIT_LO, Q_RESP} q_state_e;
    localparam logic [2:0] MASK_BYTE = 3'b001;
    localparam logic [2:0] MASK_HALF = 3'b011;
    localparam logic [2:0] MASK_WORD = 3'b111;
    localparam logic [31:0] LED_ADDR = 32'h0000_2000;
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sign_mask;
    } lsu_req_t;
    localparam int REQ_W = $bits(lsu_req_t);
    // Illegal size encodings are reported the same way as misaligned addresses.
    function automatic logic misaligned(input logic [3:0] m, input logic [31:0] a);
        return (m[2:0] == MASK_HALF) ? a[0] :
               (m[2:0] == MASK_WORD) ? (a[1:0] != 2'b00) :
               (m[2:0] != MASK_BYTE);
    endfunction
endpackage

// File: rtl/lsu_sync_fifo.sv
// lsu_sync_fifo: single-clock FIFO, DEPTH a power of two, count-based full/empty
// Ports: push_i/wdata_i write side, pop_i/rdata_o read side (rdata_o shows the head), full_o/empty_o status.
module lsu_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic do_push, do_pop;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/lsu_req_queue.sv
// lsu_req_queue: buffers LSU requests and sequences them one at a time onto a stalling data cache
// Ports: req_* request handshake in, cache command out (addr/write_data/memread/memwrite/sign_mask),
// read_data_i/clk_stall_i from the cache, rsp_* one-cycle response strobe, busy_o activity flag.
module lsu_req_queue
    import lsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_sign_mask_i,
    output logic [31:0] addr_o,
    output logic [31:0] write_data_o,
    output logic        memread_o,
    output logic        memwrite_o,
    output logic [3:0]  sign_mask_o,
    input  logic [31:0] read_data_i,
    input  logic        clk_stall_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_is_load_o,
    output logic        rsp_err_o,
    output logic        busy_o
);
    q_state_e state_q, state_d;
    lsu_req_t req, head;
    logic full, empty, issue, mis, cmd;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0] mask_q, mask_d;
    logic err_q, err_d, is_load_q, is_load_d;
    assign req = '{write: req_write_i, addr: req_addr_i, wdata: req_wdata_i, sign_mask: req_sign_mask_i};
    assign req_ready_o = !full;
    lsu_sync_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (req_valid_i),
        .wdata_i (req),
        .pop_i   (issue),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );
    assign issue = state_q == Q_ISSUE;
    assign mis   = misaligned(head.sign_mask, head.addr);
    // A rejected entry still pops, but never reaches the cache.
    assign cmd        = issue && !mis;
    assign memread_o  = cmd && !head.write;
    assign memwrite_o = cmd && head.write;
    always_comb begin
        state_d = state_q;
        case (state_q)
            Q_IDLE:    state_d = (!empty && !clk_stall_i) ? Q_ISSUE : Q_IDLE;
            Q_ISSUE:   state_d = mis ? Q_RESP : Q_WAIT_HI;
            Q_WAIT_HI: state_d = clk_stall_i ? Q_WAIT_LO : Q_WAIT_HI;
            Q_WAIT_LO: state_d = clk_stall_i ? Q_WAIT_LO : Q_RESP;
            Q_RESP:    state_d = empty ? Q_IDLE : Q_ISSUE;
            default:   state_d = Q_IDLE;
        endcase
    end
    // Cache-side fields follow the head during issue and hold the last issued command otherwise.
    always_comb begin
        addr_d    = cmd ? head.addr : addr_q;
        wdata_d   = cmd ? head.wdata : wdata_q;
        mask_d    = cmd ? head.sign_mask : mask_q;
        err_d     = issue ? mis : err_q;
        is_load_d = issue ? !head.write : is_load_q;
        rdata_d   = issue ? '0 :
                    (state_q == Q_WAIT_LO && !clk_stall_i && is_load_q) ? read_data_i : rdata_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= Q_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            is_load_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            is_load_q <= is_load_d;
            rdata_q   <= rdata_d;
        end
    end
    assign addr_o        = addr_d;
    assign write_data_o  = wdata_d;
    assign sign_mask_o   = mask_d;
    assign rsp_valid_o   = state_q == Q_RESP;
    assign rsp_err_o     = rsp_valid_o && err_q;
    assign rsp_is_load_o = rsp_valid_o && is_load_q;
    assign rsp_rdata_o   = rdata_q;
    assign busy_o        = !empty || state_q != Q_IDLE;
endmodule
